// File: rtl/taxi_apb_arb_pkg.sv
// Shared types for the APB arbiter: transfer state encoding and index-width helper.
package taxi_apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Width of an index into n ports; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// APB4 bus bundle with optional user sidebands; *_EN marks a sideband as carrying meaning.
interface taxi_apb_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int STRB_W    = DATA_W/8,
  parameter bit PAUSER_EN = 1'b0,
  parameter int PAUSER_W  = 1,
  parameter bit PWUSER_EN = 1'b0,
  parameter int PWUSER_W  = 1,
  parameter bit PRUSER_EN = 1'b0,
  parameter int PRUSER_W  = 1,
  parameter bit PBUSER_EN = 1'b0,
  parameter int PBUSER_W  = 1
) ();

  logic [ADDR_W-1:0]   paddr;
  logic [2:0]          pprot;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [STRB_W-1:0]   pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;
  logic [PAUSER_W-1:0] pauser;
  logic [PWUSER_W-1:0] pwuser;
  logic [PRUSER_W-1:0] pruser;
  logic [PBUSER_W-1:0] pbuser;

  modport mst (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    input  pready, prdata, pslverr, pruser, pbuser
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    output pready, prdata, pslverr, pruser, pbuser
  );

endinterface

// File: rtl/taxi_arb_rr_sel.sv
// Round-robin pick: first requester at or after ptr, scanning upward with wrap.
// Purely combinational; rotate the request vector by ptr, priority-encode, then un-rotate.
module taxi_arb_rr_sel
  import taxi_apb_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         vld,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W:0]   sum;

  always_comb begin
    rot = N'({req, req} >> ptr);
    vld = |req;
    sum = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = (W+1)'(k);
      end
    end
    // ptr is always below N, so a single conditional subtract is a full mod-N
    sum = sum + {1'b0, ptr};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/taxi_apb_arbiter.sv
// Round-robin arbiter sharing one APB completer among M_CNT requesters, one transfer in flight.
// Optional access-phase timeout under `TAXI_APB_ARB_TIMEOUT_EN (times out with pslverr=1, prdata=0).
module taxi_apb_arbiter
  import taxi_apb_arb_pkg::*;
#(
  parameter int M_CNT   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  taxi_apb_if.slv                 s_apb[M_CNT],
  taxi_apb_if.mst                 m_apb,
  output logic [idx_w(M_CNT)-1:0] grant_idx
);

  localparam int IDX_W     = idx_w(M_CNT);
  localparam int ADDR_W    = m_apb.ADDR_W;
  localparam int DATA_W    = m_apb.DATA_W;
  localparam int STRB_W    = m_apb.STRB_W;
  localparam int PAUSER_W  = m_apb.PAUSER_W;
  localparam int PWUSER_W  = m_apb.PWUSER_W;
  localparam int PRUSER_W  = m_apb.PRUSER_W;
  localparam int PBUSER_W  = m_apb.PBUSER_W;
  localparam bit PAUSER_EN = m_apb.PAUSER_EN;
  localparam bit PWUSER_EN = m_apb.PWUSER_EN;
  localparam bit PRUSER_EN = m_apb.PRUSER_EN;
  localparam bit PBUSER_EN = m_apb.PBUSER_EN;

  if (M_CNT < 1 || M_CNT > 16 || TIMEOUT < 1) begin : g_param_chk
    $error("taxi_apb_arbiter: M_CNT must be 1..16 and TIMEOUT at least 1");
  end

  state_t             state, state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;
  logic               timeout;
  logic               xfer_done;
  logic [M_CNT-1:0]   req;

  logic [ADDR_W-1:0]   s_paddr  [M_CNT];
  logic [2:0]          s_pprot  [M_CNT];
  logic                s_pwrite [M_CNT];
  logic [DATA_W-1:0]   s_pwdata [M_CNT];
  logic [STRB_W-1:0]   s_pstrb  [M_CNT];
  logic [PAUSER_W-1:0] s_pauser [M_CNT];
  logic [PWUSER_W-1:0] s_pwuser [M_CNT];

  logic [M_CNT-1:0]    rsp_pready;
  logic [M_CNT-1:0]    rsp_pslverr;
  logic [DATA_W-1:0]   rsp_prdata [M_CNT];
  logic [PRUSER_W-1:0] rsp_pruser [M_CNT];
  logic [PBUSER_W-1:0] rsp_pbuser [M_CNT];

  logic                m_psel;
  logic                m_penable;
  logic [ADDR_W-1:0]   m_paddr;
  logic [2:0]          m_pprot;
  logic                m_pwrite;
  logic [DATA_W-1:0]   m_pwdata;
  logic [STRB_W-1:0]   m_pstrb;
  logic [PAUSER_W-1:0] m_pauser;
  logic [PWUSER_W-1:0] m_pwuser;

  for (genvar i = 0; i < M_CNT; i++) begin : g_port
    // A port already holding pready is finishing; it must not re-request that cycle.
    assign req[i]      = s_apb[i].psel && s_apb[i].penable && !rsp_pready[i];
    assign s_paddr[i]  = s_apb[i].paddr;
    assign s_pprot[i]  = s_apb[i].pprot;
    assign s_pwrite[i] = s_apb[i].pwrite;
    assign s_pwdata[i] = s_apb[i].pwdata;
    assign s_pstrb[i]  = s_apb[i].pstrb;
    assign s_pauser[i] = s_apb[i].pauser;
    assign s_pwuser[i] = s_apb[i].pwuser;

    assign s_apb[i].pready  = rsp_pready[i];
    assign s_apb[i].prdata  = rsp_prdata[i];
    assign s_apb[i].pslverr = rsp_pslverr[i];
    assign s_apb[i].pruser  = rsp_pruser[i];
    assign s_apb[i].pbuser  = rsp_pbuser[i];
  end

  assign m_apb.psel    = m_psel;
  assign m_apb.penable = m_penable;
  assign m_apb.paddr   = m_paddr;
  assign m_apb.pprot   = m_pprot;
  assign m_apb.pwrite  = m_pwrite;
  assign m_apb.pwdata  = m_pwdata;
  assign m_apb.pstrb   = m_pstrb;
  assign m_apb.pauser  = m_pauser;
  assign m_apb.pwuser  = m_pwuser;

  taxi_arb_rr_sel #(
    .N (M_CNT),
    .W (IDX_W)
  ) u_rr_sel (
    .req (req),
    .ptr (rr_ptr),
    .vld (sel_vld),
    .idx (sel_idx)
  );

`ifdef TAXI_APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts completed ACCESS cycles; zero on entry, so the limit hits on the TIMEOUT-th cycle.
  always_ff @(posedge clk) begin
    if (rst || state != ACCESS) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign xfer_done = m_apb.pready || timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_vld) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (xfer_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_idx <= sel_idx;
          m_psel    <= 1'b1;
          for (int i = 0; i < M_CNT; i++) begin
            if (sel_idx == IDX_W'(i)) begin
              m_paddr  <= s_paddr[i];
              m_pprot  <= s_pprot[i];
              m_pwrite <= s_pwrite[i];
              m_pwdata <= s_pwdata[i];
              m_pstrb  <= s_pstrb[i];
              m_pauser <= PAUSER_EN ? s_pauser[i] : '0;
              m_pwuser <= PWUSER_EN ? s_pwuser[i] : '0;
            end
          end
        end
      end
      SETUP: begin
        m_penable <= 1'b1;
      end
      ACCESS: begin
        if (xfer_done) begin
          m_psel    <= 1'b0;
          m_penable <= 1'b0;
          for (int i = 0; i < M_CNT; i++) begin
            if (grant_idx == IDX_W'(i)) begin
              rsp_pready[i] <= 1'b1;
              // A completer pready wins over a coincident timeout.
              if (m_apb.pready) begin
                rsp_prdata[i]  <= m_apb.prdata;
                rsp_pslverr[i] <= m_apb.pslverr;
                rsp_pruser[i]  <= PRUSER_EN ? m_apb.pruser : '0;
                rsp_pbuser[i]  <= PBUSER_EN ? m_apb.pbuser : '0;
              end else begin
                rsp_prdata[i]  <= '0;
                rsp_pslverr[i] <= 1'b1;
                rsp_pruser[i]  <= '0;
                rsp_pbuser[i]  <= '0;
              end
            end
          end
        end
      end
      RESP: begin
        rsp_pready <= '0;
        rr_ptr     <= (grant_idx == IDX_W'(M_CNT - 1)) ? '0 : grant_idx + 1'b1;
      end
      default: ;
    endcase

    if (rst) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      m_psel      <= 1'b0;
      m_penable   <= 1'b0;
      rsp_pready  <= '0;
      rsp_pslverr <= '0;
      for (int i = 0; i < M_CNT; i++) begin
        rsp_prdata[i] <= '0;
        rsp_pruser[i] <= '0;
        rsp_pbuser[i] <= '0;
      end
    end
  end

endmodule
